// File: rtl/seq_alu_if.sv
// Shared word width / opcode definitions and the start/done bus between the
// execute-stage issuer (master) and seq_alu (slave).
`ifndef WORD
`define WORD 32
`endif
`ifndef ALU_AND
`define ALU_AND  4'b0000
`endif
`ifndef ALU_ORR
`define ALU_ORR  4'b0001
`endif
`ifndef ALU_ADD
`define ALU_ADD  4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'b0011
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'b0100
`endif
`ifndef ALU_MUL
`define ALU_MUL  4'b1000
`endif
`ifndef ALU_UDIV
`define ALU_UDIV 4'b1001
`endif

interface seq_alu_if #(
    parameter int WIDTH = `WORD
);
    logic             start;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output start, alu_control, a_in, b_in,
        input  busy, done, alu_result, zero, negative, carry, overflow
    );

    modport slave (
        input  start, alu_control, a_in, b_in,
        output busy, done, alu_result, zero, negative, carry, overflow
    );
endinterface

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: start/done handshake, NZCV flags, iterative multiply,
// and an iterative unsigned divide compiled in only when SEQ_ALU_UDIV_EN is defined.
module seq_alu #(
    parameter int WIDTH = `WORD,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic      clk,
    input logic      reset,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef SEQ_ALU_UDIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             zero_q, zero_d, negative_q, negative_d;
    logic             carry_q, carry_d, overflow_q, overflow_d;

    logic             launch;
    logic             fin;
    logic [WIDTH-1:0] fin_result;
    logic             fin_c, fin_v;
    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] mul_acc;

    assign launch   = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign add_full = {1'b0, bus.a_in} + {1'b0, bus.b_in};
    assign sub_full = {1'b0, bus.a_in} + {1'b0, ~bus.b_in} + (WIDTH+1)'(1);
    assign mul_acc  = b_q[0] ? acc_q + a_q : acc_q;

`ifdef SEQ_ALU_UDIV_EN
    // Divisor sits in a_q, dividend shifts out of b_q while quotient bits shift in.
    logic [WIDTH:0] div_trial;
    assign div_trial = {acc_q, b_q[WIDTH-1]} - {1'b0, a_q};
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        result_d   = result_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        fin        = 1'b0;
        fin_result = '0;
        fin_c      = 1'b0;
        fin_v      = 1'b0;

        case (state_q)
            ST_MUL: begin
                acc_d = mul_acc;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fin        = 1'b1;
                    fin_result = mul_acc;
                end else begin
                    busy_d = 1'b1;
                end
            end
`ifdef SEQ_ALU_UDIV_EN
            ST_DIV: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = div_trial[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[WIDTH-2:0], b_q[WIDTH-1]};
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    fin        = 1'b1;
                    fin_result = b_d;
                end else begin
                    busy_d = 1'b1;
                end
            end
`endif
            // IDLE and DONE both accept a new start, so back-to-back issue loses no cycle.
            default: begin
                state_d = ST_IDLE;
                if (launch) begin
                    case (bus.alu_control)
                        `ALU_AND: begin
                            fin        = 1'b1;
                            fin_result = bus.a_in & bus.b_in;
                        end
                        `ALU_ORR: begin
                            fin        = 1'b1;
                            fin_result = bus.a_in | bus.b_in;
                        end
                        `ALU_ADD: begin
                            fin        = 1'b1;
                            fin_result = add_full[WIDTH-1:0];
                            fin_c      = add_full[WIDTH];
                            fin_v      = (bus.a_in[WIDTH-1] == bus.b_in[WIDTH-1]) &&
                                         (add_full[WIDTH-1] != bus.a_in[WIDTH-1]);
                        end
                        `ALU_SUB: begin
                            fin        = 1'b1;
                            fin_result = sub_full[WIDTH-1:0];
                            fin_c      = sub_full[WIDTH];
                            fin_v      = (bus.a_in[WIDTH-1] != bus.b_in[WIDTH-1]) &&
                                         (sub_full[WIDTH-1] != bus.a_in[WIDTH-1]);
                        end
                        `ALU_PASS: begin
                            fin        = 1'b1;
                            fin_result = bus.b_in;
                        end
                        `ALU_MUL: begin
                            a_d     = bus.a_in;
                            b_d     = bus.b_in;
                            acc_d   = '0;
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = ST_MUL;
                            busy_d  = 1'b1;
                        end
`ifdef SEQ_ALU_UDIV_EN
                        `ALU_UDIV: begin
                            if (bus.b_in != '0) begin
                                a_d     = bus.b_in;
                                b_d     = bus.a_in;
                                acc_d   = '0;
                                cnt_d   = CNT_W'(WIDTH);
                                state_d = ST_DIV;
                                busy_d  = 1'b1;
                            end else begin
                                fin        = 1'b1;
                                fin_result = '1;
                            end
                        end
`endif
                        default: begin
                            fin = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        if (fin) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            result_d   = fin_result;
            zero_d     = (fin_result == '0);
            negative_d = fin_result[WIDTH-1];
            carry_d    = fin_c;
            overflow_d = fin_v;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.negative   = negative_q;
    assign bus.carry      = carry_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=64): stimulus pushes expectations into a
// scoreboard queue, a negedge monitor pops and checks on every done pulse.
`timescale 1ns/1ps
module tb_seq_alu;
    localparam int W = 64;

    typedef struct {
        string      name;
        logic [W-1:0] result;
        logic [3:0] nzcv;
        int         latency;
        int         issue_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t         sb[$];
    exp_t         mon_e;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           busy_run = 0;
    logic [W-1:0] held_result = '0;
    logic [3:0]   held_nzcv = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation; outputs hold otherwise.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
                end else begin
                    mon_e = sb.pop_front();
                    check_output({mon_e.name, " result"}, bus.alu_result, mon_e.result);
                    check_output({mon_e.name, " nzcv"},
                                 W'({bus.negative, bus.zero, bus.carry, bus.overflow}), W'(mon_e.nzcv));
                    check_output({mon_e.name, " latency"}, W'(cyc - mon_e.issue_cyc), W'(mon_e.latency));
                    check_output({mon_e.name, " busy_cycles"}, W'(busy_run), W'(mon_e.latency - 1));
                    check_output({mon_e.name, " busy_in_done"}, W'(bus.busy), W'(0));
                    held_result = mon_e.result;
                    held_nzcv   = mon_e.nzcv;
                end
                busy_run = 0;
            end else begin
                if (bus.busy) busy_run++;
                check_output("held result", bus.alu_result, held_result);
                check_output("held nzcv",
                             W'({bus.negative, bus.zero, bus.carry, bus.overflow}), W'(held_nzcv));
            end
        end
    end

    task automatic apply_stimulus(input string name, input logic [3:0] op,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] exp_res, input logic [3:0] exp_nzcv,
                                  input int lat);
        exp_t e;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.alu_control = op;
        bus.a_in        = a;
        bus.b_in        = b;
        e.name      = name;
        e.result    = exp_res;
        e.nzcv      = exp_nzcv;
        e.latency   = lat;
        e.issue_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.alu_control = 4'b0000;
        bus.a_in        = '0;
        bus.b_in        = '0;
        reset           = 1'b0;
        #2 reset = 1'b1;
        #3;
        check_output("reset busy", W'(bus.busy), W'(0));
        check_output("reset done", W'(bus.done), W'(0));
        check_output("reset result", bus.alu_result, '0);
        check_output("reset nzcv", W'({bus.negative, bus.zero, bus.carry, bus.overflow}), W'(0));
        @(negedge clk);
        reset = 1'b0;

        apply_stimulus("add", `ALU_ADD, 64'd10, 64'd15, 64'd25, 4'b0000, 1);
        apply_stimulus("sub_b2b", `ALU_SUB, 64'd10, 64'd15, 64'hFFFF_FFFF_FFFF_FFFB, 4'b1000, 1);
        apply_stimulus("add_ovf", `ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                       64'h8000_0000_0000_0000, 4'b1001, 1);
        apply_stimulus("sub_zero", `ALU_SUB, 64'h40, 64'h40, 64'd0, 4'b0110, 1);
        apply_stimulus("add_wrap", `ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1);
        apply_stimulus("sub_negovf", `ALU_SUB, 64'h8000_0000_0000_0000, 64'd1,
                       64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 1);
        apply_stimulus("and", `ALU_AND, 64'hF0F0, 64'h0FF0, 64'h00F0, 4'b0000, 1);
        apply_stimulus("orr", `ALU_ORR, 64'hF000, 64'h000F, 64'hF00F, 4'b0000, 1);
        apply_stimulus("pass", `ALU_PASS, 64'hDEAD, 64'h1234, 64'h1234, 4'b0000, 1);
        apply_stimulus("unknown", 4'b1111, 64'd3, 64'd4, 64'd0, 4'b0100, 1);
        drain(10);

        // Operand changes and a second start during busy must not disturb the multiply.
        apply_stimulus("mul", `ALU_MUL, 64'd65536, 64'd65536, 64'h1_0000_0000, 4'b0000, W + 1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start       = 1'b1;
        bus.alu_control = `ALU_ADD;
        bus.a_in        = 64'd1;
        bus.b_in        = 64'd2;
        repeat (3) @(negedge clk);
        bus.start       = 1'b0;
        bus.alu_control = `ALU_SUB;
        bus.a_in        = 64'd7;
        bus.b_in        = 64'd9;
        drain(100);

        apply_stimulus("mul_wrap", `ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
                       64'hFFFF_FFFF_FFFF_FFFD, 4'b1000, W + 1);
        drain(100);

`ifdef SEQ_ALU_UDIV_EN
        apply_stimulus("udiv", `ALU_UDIV, 64'd100, 64'd7, 64'd14, 4'b0000, W + 1);
        drain(100);
        apply_stimulus("udiv_big", `ALU_UDIV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,
                       64'h0FFF_FFFF_FFFF_FFFF, 4'b0000, W + 1);
        drain(100);
        apply_stimulus("udiv_by0", `ALU_UDIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1);
        drain(10);
`else
        apply_stimulus("udiv_off", `ALU_UDIV, 64'd100, 64'd7, 64'd0, 4'b0100, 1);
        drain(10);
        apply_stimulus("udiv_off_by0", `ALU_UDIV, 64'd5, 64'd0, 64'd0, 4'b0100, 1);
        drain(10);
`endif

        apply_stimulus("sub_setup", `ALU_SUB, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1);
        drain(10);

        // Abort a multiply with reset: outputs clear at once and the pending done is dropped.
        apply_stimulus("mul_aborted", `ALU_MUL, 64'd3, 64'd5, 64'd15, 4'b0000, W + 1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("abort busy", W'(bus.busy), W'(0));
        check_output("abort done", W'(bus.done), W'(0));
        check_output("abort result", bus.alu_result, '0);
        check_output("abort nzcv", W'({bus.negative, bus.zero, bus.carry, bus.overflow}), W'(0));
        sb.delete();
        held_result = '0;
        held_nzcv   = 4'b0000;
        busy_run    = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 5) @(negedge clk);

        apply_stimulus("pass_zero", `ALU_PASS, 64'hDEAD, 64'd0, 64'd0, 4'b0100, 1);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered execute-stage ALU that extends the combinational single-cycle ALU with a start/done handshake, NZCV flag generation and iterative multi-cycle operations: an unsigned/low-half multiply and, optionally, an unsigned divide. It sits in the execute stage between the operand-forwarding muxes and the EX/MEM pipeline register. The pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default `` `WORD ``: operand and result width in bits (legal 8..64).
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width (derived, not overridden).

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  launch an operation; sampled only when `busy`=0.
- `alu_control`  input  4  opcode: `` `ALU_AND ``, `` `ALU_ORR ``, `` `ALU_ADD ``, `` `ALU_SUB ``, `` `ALU_PASS `` (existing), plus `` `ALU_MUL ``=4'b1000 and `` `ALU_UDIV ``=4'b1001 (added to the shared definitions header).
- `a_in`  input  WIDTH  operand A; captured at start.
- `b_in`  input  WIDTH  operand B; captured at start.
- `busy`  output  1  multi-cycle operation in progress; new starts are ignored.
- `done`  output  1  one-cycle pulse; `alu_result` and flags are valid from this cycle.
- `alu_result`  output  WIDTH  registered result, held until the next done.
- `zero`  output  1  `alu_result`==0.
- `negative`  output  1  `alu_result[WIDTH-1]`.
- `carry`  output  1  carry-out of ADD; NOT-borrow of SUB (ARM convention); 0 for all other ops.
- `overflow`  output  1  signed overflow of ADD/SUB; 0 for all other ops.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE with `start`=1:
  - AND, ORR, ADD, SUB, PASS (result = `b_in`) go to DONE.
  - MUL: latch operands, clear the accumulator, load counter = WIDTH, go to MUL.
  - UDIV with `b_in`≠0: go to DIV.
  - UDIV with `b_in`=0: result all-ones, go to DONE.
  - Unknown opcode: result 0, go to DONE.
- MUL: radix-2 shift-add, one multiplier bit per cycle. After WIDTH iterations go to DONE. Result = low WIDTH bits of a×b; carry and overflow are 0.
- DIV: restoring shift-subtract, one quotient bit per cycle. After WIDTH iterations go to DONE. Result = quotient; the remainder is discarded.
- DONE: assert `done` for one cycle, return to IDLE.
  - If `start`=1 in DONE, it is accepted exactly as from IDLE, so back-to-back operations lose no cycle.
- Operands and opcode are captured at start. Later changes on `a_in`, `b_in` or `alu_control` have no effect on an operation in flight.
- Flags are computed from the final result and registered together with `alu_result`.
- All arithmetic is modulo 2^WIDTH.

## Timing
- Reset (asynchronous, immediate): state=IDLE; `busy`, `done`, `alu_result`, `zero`, `negative`, `carry`, `overflow` all 0.
  - Reset mid-MUL or mid-DIV aborts the operation; no `done` is issued.
- Latency is measured from the edge that samples `start` to the edge that raises `done`:
  - 1 cycle for AND, ORR, ADD, SUB, PASS, UDIV-by-zero and unknown opcodes.
  - WIDTH+1 cycles for MUL and UDIV.
- `busy`=1 exactly while state ∈ {MUL, DIV}; `busy` is 0 in the `done` cycle.
- `start` while `busy`=1 is dropped with no queueing. The issuer must hold `start` or re-issue it.
- `alu_result` and the flags change only on the edge that raises `done`.

## Configuration
- `SEQ_ALU_UDIV_EN` defined: the DIV state, divider datapath and `` `ALU_UDIV `` decode are compiled in.
- `SEQ_ALU_UDIV_EN` undefined: no DIV state. `` `ALU_UDIV `` is treated as an unknown opcode (result 0, `zero`=1, latency 1).

## Test plan
- ADD, WIDTH=64: a=10, b=15, start → one cycle later `done`=1, result=25, NZCV=0000. Then SUB a=10, b=15 back-to-back in the DONE cycle → result=-5, N=1, C=0, V=0.
- Flags, WIDTH=8: ADD a=8'h7F, b=1 → result 8'h80, N=1, V=1, C=0. SUB a=b=8'h40 → result 0, Z=1, C=1.
- MUL, WIDTH=64: a=65536, b=65536 → `busy` high for 64 cycles, `done` on cycle 65, result=2^32. Operands changed mid-operation and a second `start` during `busy` → both ignored.
- UDIV with macro defined: a=100, b=7 → result=14 after 65 cycles. a=5, b=0 → all-ones after 1 cycle, N=1.
- Without the macro: UDIV a=100, b=7 → result 0, `zero`=1 after 1 cycle.
- Reset asserted at MUL cycle 20 → all outputs 0 immediately, no `done`. A subsequent PASS with b=0 → result 0, `zero`=1 after 1 cycle.
